// File: rtl/sm_icache_pkg.sv
// Shared definitions for the sm_icache instruction cache:
// FSM state encoding and geometry helpers.
package sm_icache_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_REFILL = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    function automatic int tag_w(input int addr_w, input int index_w, input int offset_w);
        return addr_w - index_w - offset_w;
    endfunction

    function automatic int lines(input int index_w);
        return 1 << index_w;
    endfunction

    function automatic int words(input int offset_w);
        return 1 << offset_w;
    endfunction

endpackage

// File: rtl/sm_icache_store.sv
// Line storage for sm_icache: valid bits (reset), tags and data words
// (not reset), async read, per-word data write, line commit and bulk clear.
module sm_icache_store
    import sm_icache_pkg::*;
#(
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 2,
    parameter int TAG_W    = 26
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_clr,
    input  logic [INDEX_W-1:0]  i_idx,
    input  logic [OFFSET_W-1:0] i_rd_off,
    output logic                o_vld,
    output logic [TAG_W-1:0]    o_tag,
    output logic [31:0]         o_word,
    input  logic                i_wr_en,
    input  logic [OFFSET_W-1:0] i_wr_off,
    input  logic [31:0]         i_wr_data,
    input  logic                i_commit,
    input  logic [TAG_W-1:0]    i_commit_tag,
    input  logic                i_commit_vld
);

    localparam int LINES = lines(INDEX_W);
    localparam int WORDS = words(OFFSET_W);

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES][WORDS];

    assign o_vld  = r_valid[i_idx];
    assign o_tag  = r_tag[i_idx];
    assign o_word = r_data[i_idx][i_rd_off];

    // A commit on the same edge as a clear still lands; the caller folds the
    // clear into i_commit_vld so the refilled line stays invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else begin
            if (i_clr)
                r_valid <= '0;
            if (i_commit)
                r_valid[i_idx] <= i_commit_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en)
            r_data[i_idx][i_wr_off] <= i_wr_data;
        if (i_commit)
            r_tag[i_idx] <= i_commit_tag;
    end

endmodule

// File: rtl/sm_icache.sv
// Direct-mapped read-only instruction cache: CPU fetch port in front,
// word-wise req/ack line refill from backing memory behind.
module sm_icache
    import sm_icache_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic              cpu_valid,
    output logic [31:0]       cpu_rdata,
    input  logic              inv,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    localparam int TAG_W = tag_w(ADDR_W, INDEX_W, OFFSET_W);

    state_t                r_state, w_next;
    logic [ADDR_W-1:0]     r_addr;
    logic [OFFSET_W-1:0]   r_cnt;
    logic                  r_inv_pend;
    logic [31:0]           r_rdata, r_hit_cnt, r_miss_cnt;

    logic [TAG_W-1:0]      w_tag, w_line_tag;
    logic [INDEX_W-1:0]    w_idx;
    logic [OFFSET_W-1:0]   w_off;
    logic                  w_line_vld, w_hit, w_ack, w_last, w_accept;
    logic [31:0]           w_line_word;

    assign w_tag    = r_addr[ADDR_W-1 -: TAG_W];
    assign w_idx    = r_addr[OFFSET_W +: INDEX_W];
    assign w_off    = r_addr[OFFSET_W-1:0];
    assign w_accept = (r_state == S_IDLE) && cpu_req;
    assign w_hit    = w_line_vld && (w_line_tag == w_tag);
    assign w_ack    = (r_state == S_REFILL) && mem_ack;
    assign w_last   = w_ack && (r_cnt == '1);

    sm_icache_store #(
        .INDEX_W  (INDEX_W),
        .OFFSET_W (OFFSET_W),
        .TAG_W    (TAG_W)
    ) u_store (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (inv),
        .i_idx        (w_idx),
        .i_rd_off     (w_off),
        .o_vld        (w_line_vld),
        .o_tag        (w_line_tag),
        .o_word       (w_line_word),
        .i_wr_en      (w_ack),
        .i_wr_off     (r_cnt),
        .i_wr_data    (mem_rdata),
        .i_commit     (w_last),
        .i_commit_tag (w_tag),
        .i_commit_vld (~(r_inv_pend | inv))
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (cpu_req) w_next = S_LOOKUP;
            S_LOOKUP: w_next = w_hit ? S_RESP : S_REFILL;
            S_REFILL: if (w_last) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_inv_pend <= 1'b0;
            r_rdata    <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept)
                r_addr <= cpu_addr;
            if (r_state == S_LOOKUP)
                r_cnt <= '0;
            else if (w_ack)
                r_cnt <= r_cnt + 1'b1;
            if (r_state == S_REFILL && w_next != S_REFILL)
                r_inv_pend <= 1'b0;
            else if (r_state == S_REFILL && inv)
                r_inv_pend <= 1'b1;
            // On the final ack the requested word may be the one arriving now.
            if (r_state == S_LOOKUP && w_hit)
                r_rdata <= w_line_word;
            else if (w_last)
                r_rdata <= (w_off == r_cnt) ? mem_rdata : w_line_word;
            if (r_state == S_LOOKUP && w_hit && r_hit_cnt != '1)
                r_hit_cnt <= r_hit_cnt + 32'd1;
            if (r_state == S_LOOKUP && !w_hit && r_miss_cnt != '1)
                r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign cpu_ready = (r_state == S_IDLE);
    assign cpu_valid = (r_state == S_RESP);
    assign cpu_rdata = r_rdata;
    assign mem_req   = (r_state == S_REFILL);
    assign mem_addr  = {r_addr[ADDR_W-1:OFFSET_W], r_cnt};
    assign hit_cnt   = r_hit_cnt;
    assign miss_cnt  = r_miss_cnt;

endmodule
